// File: rtl/rc5_block_ctrl_if.sv
// ---------------------------------------------------------------------------
// rc5_block_ctrl_if
// Block-level handshake bundle between a block producer/consumer and the
// RC5 block controller.
//   iBlkA/iBlkB/iBlkMode/iBlkValid -> input block offer (mode 0=enc, 1=dec)
//   oBlkReady                      <- controller can take a block
//   oResA/oResB/oResValid          <- result presented to the consumer
//   iResReady                      -> consumer takes the result
// Modports: slave = controller side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface rc5_block_ctrl_if #(
    parameter int W = 32
);
    logic [W-1:0] iBlkA;
    logic [W-1:0] iBlkB;
    logic         iBlkMode;
    logic         iBlkValid;
    logic         oBlkReady;
    logic [W-1:0] oResA;
    logic [W-1:0] oResB;
    logic         oResValid;
    logic         iResReady;

    modport slave (
        input  iBlkA, iBlkB, iBlkMode, iBlkValid, iResReady,
        output oBlkReady, oResA, oResB, oResValid
    );

    modport master (
        output iBlkA, iBlkB, iBlkMode, iBlkValid, iResReady,
        input  oBlkReady, oResA, oResB, oResValid
    );
endinterface

// File: rtl/rc5_block_ctrl.sv
// ---------------------------------------------------------------------------
// rc5_block_ctrl
// Controller sitting in front of an RC5 core (key expander, cipher, decipher
// and their RAMs). It streams the B-byte secret key into the core key RAM,
// accepts one 2W-bit block at a time, holds the matching start level until
// the core reports done, and presents the captured result downstream.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   iKeyByte/iKeyValid       key byte stream in
//   oKeyReady/oKeyLoaded     key stream flow control / key complete flag
//   blk (rc5_block_ctrl_if)  block in and result out handshakes (slave side)
//   oKey_sub_i/oKey_address/oWen   core key RAM write port
//   oStartCipher/oStartDecipher    start levels to the core
//   oA/oB, oA_cipher/oB_cipher     core encrypt / decrypt inputs
//   iA_cipher/iB_cipher, iA_decipher/iB_decipher   core outputs
//   iDoneCipher/iDoneDecipher      core done flags
//
// Optional feature macro: RC5_CBC_EN
//   When defined, adds iIV/iIVLoad and chains blocks in CBC mode. When
//   undefined the controller is plain ECB and data passes unmodified.
// ---------------------------------------------------------------------------
module rc5_block_ctrl #(
    parameter int W        = 32,
    parameter int B        = 16,
    parameter int B_LENGTH = $clog2(B)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          iKeyByte,
    input  logic                iKeyValid,
    output logic                oKeyReady,
    output logic                oKeyLoaded,
    rc5_block_ctrl_if.slave     blk,
    output logic [7:0]          oKey_sub_i,
    output logic [B_LENGTH-1:0] oKey_address,
    output logic                oWen,
    output logic                oStartCipher,
    output logic                oStartDecipher,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic [W-1:0]        oA_cipher,
    output logic [W-1:0]        oB_cipher,
    input  logic [W-1:0]        iA_cipher,
    input  logic [W-1:0]        iB_cipher,
    input  logic [W-1:0]        iA_decipher,
    input  logic [W-1:0]        iB_decipher,
    input  logic                iDoneCipher,
    input  logic                iDoneDecipher
`ifdef RC5_CBC_EN
    ,
    input  logic [2*W-1:0]      iIV,
    input  logic                iIVLoad
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t              state_q;
    logic [B_LENGTH-1:0] keyCnt_q;
    logic                keyLoaded_q;
    logic                mode_q;
    logic [W-1:0]        resA_q;
    logic [W-1:0]        resB_q;
    logic                resValid_q;

    logic                keyAccept;
    logic                blkAccept;
    logic                ivLoad;
    logic [W-1:0]        chainA;
    logic [W-1:0]        chainB;

    // The chain halves are zero in ECB so the same datapath serves both
    // builds; an IV load wins over a block offer, so ready is withheld for
    // that cycle to keep the handshake honest.
`ifdef RC5_CBC_EN
    logic [2*W-1:0] chain_q;
    assign ivLoad = iIVLoad;
    assign chainA = chain_q[2*W-1:W];
    assign chainB = chain_q[W-1:0];
`else
    assign ivLoad = 1'b0;
    assign chainA = '0;
    assign chainB = '0;
`endif

    // Key stream flow control and key RAM write port. The write port is a
    // direct function of the registered counter so a byte lands in the RAM
    // in the cycle it is accepted. Gating with rst keeps every output low
    // while reset is held.
    assign oKeyReady     = !rst && !keyLoaded_q && (state_q == IDLE);
    assign keyAccept     = oKeyReady && iKeyValid;
    assign oWen          = keyAccept;
    assign oKey_sub_i    = keyAccept ? iKeyByte : 8'h00;
    assign oKey_address  = keyCnt_q;
    assign oKeyLoaded    = keyLoaded_q;

    // Block handshake: only one block in flight, so ready is just "key is
    // in and we are idle".
    assign blk.oBlkReady = keyLoaded_q && (state_q == IDLE) && !ivLoad;
    assign blkAccept     = blk.oBlkReady && blk.iBlkValid;
    assign blk.oResA     = resA_q;
    assign blk.oResB     = resB_q;
    assign blk.oResValid = resValid_q;

    // Single sequential block holding the key counter and the IDLE/RUN/OUT
    // machine with all of its registered outputs. The start level is set at
    // the accept edge so it is high from the following cycle, and it is
    // dropped at the edge where the matching done flag is captured. The
    // other core's done flag is never looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            keyCnt_q       <= '0;
            keyLoaded_q    <= 1'b0;
            mode_q         <= 1'b0;
            resA_q         <= '0;
            resB_q         <= '0;
            resValid_q     <= 1'b0;
            oStartCipher   <= 1'b0;
            oStartDecipher <= 1'b0;
            oA             <= '0;
            oB             <= '0;
            oA_cipher      <= '0;
            oB_cipher      <= '0;
`ifdef RC5_CBC_EN
            chain_q        <= '0;
`endif
        end else begin
            if (keyAccept) begin
                if (keyCnt_q == B_LENGTH'(B - 1)) begin
                    keyCnt_q    <= '0;
                    keyLoaded_q <= 1'b1;
                end else begin
                    keyCnt_q    <= keyCnt_q + B_LENGTH'(1);
                end
            end

            case (state_q)
                IDLE: begin
`ifdef RC5_CBC_EN
                    if (iIVLoad) begin
                        chain_q <= iIV;
                    end
`endif
                    if (blkAccept) begin
                        oA             <= blk.iBlkA ^ chainA;
                        oB             <= blk.iBlkB ^ chainB;
                        oA_cipher      <= blk.iBlkA;
                        oB_cipher      <= blk.iBlkB;
                        mode_q         <= blk.iBlkMode;
                        oStartCipher   <= !blk.iBlkMode;
                        oStartDecipher <= blk.iBlkMode;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    if (!mode_q && iDoneCipher) begin
                        resA_q       <= iA_cipher;
                        resB_q       <= iB_cipher;
                        resValid_q   <= 1'b1;
                        oStartCipher <= 1'b0;
                        state_q      <= OUT;
`ifdef RC5_CBC_EN
                        chain_q      <= {iA_cipher, iB_cipher};
`endif
                    end else if (mode_q && iDoneDecipher) begin
                        resA_q         <= iA_decipher ^ chainA;
                        resB_q         <= iB_decipher ^ chainB;
                        resValid_q     <= 1'b1;
                        oStartDecipher <= 1'b0;
                        state_q        <= OUT;
`ifdef RC5_CBC_EN
                        chain_q        <= {oA_cipher, oB_cipher};
`endif
                    end
                end
                OUT: begin
                    if (blk.iResReady) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_block_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rc5_block_ctrl
// Bench for rc5_block_ctrl (ECB build). A behavioural RC5-32/12/16 core model
// stands in for the cipher core: it keeps its own key RAM from the DUT write
// port and answers start levels after a random latency, while randomly
// toggling the unrelated done flag with junk data. Expected results come
// from the RC5 algorithm applied to the key bytes the bench streamed in.
// ---------------------------------------------------------------------------
module tb_rc5_block_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  iKeyByte = 8'h00;
    logic        iKeyValid = 1'b0;
    logic        oKeyReady, oKeyLoaded;
    logic [7:0]  oKey_sub_i;
    logic [3:0]  oKey_address;
    logic        oWen;
    logic        oStartCipher, oStartDecipher;
    logic [31:0] oA, oB, oA_cipher, oB_cipher;
    logic [31:0] iA_cipher = '0, iB_cipher = '0;
    logic [31:0] iA_decipher = '0, iB_decipher = '0;
    logic        iDoneCipher = 1'b0, iDoneDecipher = 1'b0;

    rc5_block_ctrl_if #(.W(32)) blk ();

    int total = 0;
    int bad   = 0;

    logic [127:0] refKey  = '0;
    logic [831:0] refS    = '0;
    logic [127:0] coreKey = '0;
    logic [831:0] coreS   = '0;
    int           forceLat = -1;
    int           latCore  = 0;
    int           cntCore  = 0;

    logic [63:0]  res, res2;
    logic [31:0]  pa, pb;
    logic         pm;

    always #5 clk = ~clk;

    rc5_block_ctrl #(.W(32), .B(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .iKeyByte      (iKeyByte),
        .iKeyValid     (iKeyValid),
        .oKeyReady     (oKeyReady),
        .oKeyLoaded    (oKeyLoaded),
        .blk           (blk),
        .oKey_sub_i    (oKey_sub_i),
        .oKey_address  (oKey_address),
        .oWen          (oWen),
        .oStartCipher  (oStartCipher),
        .oStartDecipher(oStartDecipher),
        .oA            (oA),
        .oB            (oB),
        .oA_cipher     (oA_cipher),
        .oB_cipher     (oB_cipher),
        .iA_cipher     (iA_cipher),
        .iB_cipher     (iB_cipher),
        .iA_decipher   (iA_decipher),
        .iB_decipher   (iB_decipher),
        .iDoneCipher   (iDoneCipher),
        .iDoneDecipher (iDoneDecipher)
`ifdef RC5_CBC_EN
        ,
        .iIV           (64'h0),
        .iIVLoad       (1'b0)
`endif
    );

    // RC5 helper arithmetic: rotations by the low five bits of the amount.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        int unsigned sh;
        sh = n & 32'd31;
        return (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] n);
        int unsigned sh;
        sh = n & 32'd31;
        return (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
    endfunction

    // Key schedule: 16-byte little-endian key into 26 round subkeys, packed.
    function automatic logic [831:0] rc5Expand(input logic [127:0] key);
        logic [31:0]  s [26];
        logic [31:0]  l [4];
        logic [31:0]  a, b;
        logic [831:0] sPack;
        int           i, j;
        for (int k = 0; k < 4; k++) l[k] = key[k*32 +: 32];
        s[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) s[k] = s[k-1] + 32'h9E3779B9;
        a = '0; b = '0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            s[i] = rotl(s[i] + a + b, 32'd3);
            a    = s[i];
            l[j] = rotl(l[j] + a + b, a + b);
            b    = l[j];
            i    = (i + 1) % 26;
            j    = (j + 1) % 4;
        end
        for (int k = 0; k < 26; k++) sPack[k*32 +: 32] = s[k];
        return sPack;
    endfunction

    function automatic logic [63:0] rc5Enc(input logic [831:0] s, input logic [31:0] a0, input logic [31:0] b0);
        logic [31:0] a, b;
        a = a0 + s[31:0];
        b = b0 + s[63:32];
        for (int i = 1; i <= 12; i++) begin
            a = rotl(a ^ b, b) + s[(2*i)*32 +: 32];
            b = rotl(b ^ a, a) + s[(2*i+1)*32 +: 32];
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] rc5Dec(input logic [831:0] s, input logic [31:0] a0, input logic [31:0] b0);
        logic [31:0] a, b;
        a = a0;
        b = b0;
        for (int i = 12; i >= 1; i--) begin
            b = rotr(b - s[(2*i+1)*32 +: 32], a) ^ a;
            a = rotr(a - s[(2*i)*32 +: 32], b) ^ b;
        end
        b = b - s[63:32];
        a = a - s[31:0];
        return {a, b};
    endfunction

    // Core key RAM model, written through the DUT's write port.
    always @(posedge clk) begin
        if (oWen) coreKey[oKey_address*8 +: 8] <= oKey_sub_i;
    end

    // Core behaviour model: answers the active start level after a random
    // latency, and meanwhile toggles the other core's done flag with junk.
    always @(negedge clk) begin
        if (rst) begin
            iDoneCipher   = 1'b0;
            iDoneDecipher = 1'b0;
            cntCore       = 0;
        end else if (oStartCipher) begin
            if (cntCore >= latCore) begin
                iDoneCipher = 1'b1;
                {iA_cipher, iB_cipher} = rc5Enc(coreS, oA, oB);
            end else begin
                cntCore++;
            end
            iDoneDecipher = 1'($urandom_range(0, 1));
            iA_decipher   = $urandom;
            iB_decipher   = $urandom;
        end else if (oStartDecipher) begin
            if (cntCore >= latCore) begin
                iDoneDecipher = 1'b1;
                {iA_decipher, iB_decipher} = rc5Dec(coreS, oA_cipher, oB_cipher);
            end else begin
                cntCore++;
            end
            iDoneCipher = 1'($urandom_range(0, 1));
            iA_cipher   = $urandom;
            iB_cipher   = $urandom;
        end else begin
            iDoneCipher   = 1'b0;
            iDoneDecipher = 1'b0;
            cntCore       = 0;
            latCore       = (forceLat >= 0) ? forceLat : int'($urandom_range(0, 4));
            coreS         = rc5Expand(coreKey);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("resetCtl", 64'({oKeyReady, oKeyLoaded, oWen, oStartCipher, oStartDecipher,
                                     blk.oBlkReady, blk.oResValid}), 64'h0);
        checkOutput("resetRes", {blk.oResA, blk.oResB}, 64'h0);
        checkOutput("resetCoreIn", {oA, oB} | {oA_cipher, oB_cipher}, 64'h0);
        checkOutput("resetKeyPort", 64'({oKey_address, oKey_sub_i}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyKey(input logic [127:0] key, input bit detail);
        refKey = key;
        refS   = rc5Expand(key);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            iKeyByte  = key[i*8 +: 8];
            iKeyValid = 1'b1;
            #1;
            if (detail) begin
                checkOutput("keyWrite", 64'({oWen, oKey_address, oKey_sub_i}),
                            64'({1'b1, 4'(i), key[i*8 +: 8]}));
                checkOutput("keyNotYetLoaded", 64'(oKeyLoaded), 64'h0);
            end
        end
        @(negedge clk);
        iKeyValid = 1'b0;
        #1;
        checkOutput("keyLoaded", 64'({oKeyLoaded, oKeyReady}), 64'b10);
    endtask

    // One block through the controller: offer, accept, start level, result
    // check, optional hold with iResReady low, then the result handshake.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic mode,
                                 input int holdCycles, output logic [63:0] result);
        int          cnt;
        logic [63:0] exp;
        exp    = mode ? rc5Dec(refS, a, b) : rc5Enc(refS, a, b);
        result = '0;
        @(negedge clk);
        blk.iBlkA     = a;
        blk.iBlkB     = b;
        blk.iBlkMode  = mode;
        blk.iBlkValid = 1'b1;
        #1;
        cnt = 0;
        while (!blk.oBlkReady && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (!blk.oBlkReady) begin
            checkOutput("acceptTimeout", 64'h0, 64'h1);
            blk.iBlkValid = 1'b0;
            return;
        end
        @(negedge clk);
        blk.iBlkValid = 1'b0;
        blk.iBlkA     = $urandom;
        blk.iBlkB     = $urandom;
        blk.iBlkMode  = 1'($urandom_range(0, 1));
        checkOutput("coreIn", mode ? {oA_cipher, oB_cipher} : {oA, oB}, {a, b});
        cnt = 0;
        while (!blk.oResValid && cnt < 50) begin
            checkOutput("startHeld", 64'({oStartCipher, oStartDecipher}), mode ? 64'b01 : 64'b10);
            @(negedge clk);
            cnt++;
        end
        if (!blk.oResValid) begin
            checkOutput("resultTimeout", 64'h0, 64'h1);
            return;
        end
        result = {blk.oResA, blk.oResB};
        checkOutput("result", result, exp);
        checkOutput("startDropped", 64'({oStartCipher, oStartDecipher}), 64'h0);
        checkOutput("noReadyInOut", 64'(blk.oBlkReady), 64'h0);
        repeat (holdCycles) begin
            @(negedge clk);
            checkOutput("holdData", {blk.oResA, blk.oResB}, result);
            checkOutput("holdCtl", 64'({blk.oResValid, blk.oBlkReady}), 64'b10);
        end
        blk.iResReady = 1'b1;
        @(negedge clk);
        blk.iResReady = 1'b0;
        checkOutput("resultCleared", 64'(blk.oResValid), 64'h0);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic   seen;
        logic [127:0] seqKey;
        logic [127:0] rndKey;
        int     cnt;

        blk.iBlkA = '0; blk.iBlkB = '0; blk.iBlkMode = 1'b0;
        blk.iBlkValid = 1'b0; blk.iResReady = 1'b0;
        for (int i = 0; i < 16; i++) seqKey[i*8 +: 8] = 8'(i);

        applyReset();

        // A block offered before the key is in must be ignored.
        @(negedge clk);
        blk.iBlkValid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            checkOutput("preKeyNoAccept", 64'({blk.oBlkReady, oStartCipher, oStartDecipher}), 64'h0);
        end
        blk.iBlkValid = 1'b0;

        applyKey(seqKey, 1'b1);

        // Extra key bytes after completion are not taken.
        @(negedge clk);
        iKeyValid = 1'b1;
        iKeyByte  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("extraKeyIgnored", 64'({oWen, oKeyReady}), 64'h0);
        end
        iKeyValid = 1'b0;

        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), res);
        end

        // Reference vector with the all-zero key, then its inverse while
        // holding the result for ten cycles.
        applyReset();
        applyKey(128'h0, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b0, 0, res);
        checkOutput("refVector", res, 64'hEEDBA521_6D8F4B15);
        applyStimulus(res[63:32], res[31:0], 1'b1, 10, res2);
        checkOutput("refVectorInverse", res2, 64'h0);

        // Random key, random blocks and round trips.
        applyReset();
        rndKey = {$urandom, $urandom, $urandom, $urandom};
        applyKey(rndKey, 1'b0);
        for (int n = 0; n < 10; n++) begin
            pa = $urandom;
            pb = $urandom;
            pm = 1'($urandom_range(0, 1));
            applyStimulus(pa, pb, pm, $urandom_range(0, 4), res);
            applyStimulus(res[63:32], res[31:0], ~pm, $urandom_range(0, 2), res2);
            checkOutput("roundTrip", res2, {pa, pb});
        end

        // Reset while the core is busy: start drops at once and no result.
        forceLat = 30;
        @(negedge clk);
        blk.iBlkA = $urandom; blk.iBlkB = $urandom; blk.iBlkMode = 1'b0;
        blk.iBlkValid = 1'b1;
        #1;
        cnt = 0;
        while (!blk.oBlkReady && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        @(negedge clk);
        blk.iBlkValid = 1'b0;
        checkOutput("midRunStart", 64'({oStartCipher, oStartDecipher}), 64'b10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRunReset", 64'({oStartCipher, oStartDecipher, oKeyLoaded, blk.oResValid}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        forceLat = -1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | blk.oResValid | oStartCipher | oStartDecipher;
        end
        checkOutput("discardedBlock", 64'(seen), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
